// File: rtl/ts_tick_gen.sv
// Multi-channel timebase: divides clock into a precision tick, then per channel
// into unit ticks; each channel runs for a programmed number of units.
module ts_tick_gen #(
   parameter int CHANNELS = 4,
   parameter int PREC_DIV = 10,
   parameter int RATIO_W  = 8,
   parameter int CNT_W    = 16
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic                        stop,
   input  logic [CHANNELS*RATIO_W-1:0] unit_ratio,
   input  logic [CHANNELS*CNT_W-1:0]   unit_limit,
   output logic [CHANNELS-1:0]         tick,
   output logic [CHANNELS*CNT_W-1:0]   unit_count,
   output logic [CHANNELS-1:0]         done,
   output logic                        busy,
   output logic                        all_done
);

   localparam int PW = (PREC_DIV > 1) ? $clog2(PREC_DIV) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FINISH
   } state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       presc_q;
   logic                prec_tick;
   logic [RATIO_W-1:0]  ratio_q [CHANNELS];
   logic [RATIO_W-1:0]  sub_q   [CHANNELS];
   logic [CNT_W-1:0]    limit_q [CHANNELS];
   logic [CNT_W-1:0]    count_q [CHANNELS];
   logic [CHANNELS-1:0] tick_q;
   logic [CHANNELS-1:0] done_q;
   logic                busy_q;
   logic                all_done_q;

   always_comb prec_tick = (presc_q == PW'(PREC_DIV - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN: begin
            if (stop)         state_d = IDLE;
            else if (&done_q) state_d = FINISH;
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // busy/all_done are registered from the next state so they line up with it.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         all_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= (state_d != IDLE);
         all_done_q <= (state_d == FINISH);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         presc_q <= '0;
         tick_q  <= '0;
         done_q  <= '0;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            ratio_q[i] <= '0;
            sub_q[i]   <= '0;
            limit_q[i] <= '0;
            count_q[i] <= '0;
         end
      end else begin
         tick_q <= '0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  presc_q <= '0;
                  for (int unsigned i = 0; i < CHANNELS; i++) begin
                     ratio_q[i] <= (unit_ratio[i*RATIO_W +: RATIO_W] == '0) ?
                                   RATIO_W'(1) : unit_ratio[i*RATIO_W +: RATIO_W];
                     limit_q[i] <= unit_limit[i*CNT_W +: CNT_W];
                     sub_q[i]   <= '0;
                     count_q[i] <= '0;
                     // zero-limit channels are done from the first RUN cycle
                     done_q[i]  <= (unit_limit[i*CNT_W +: CNT_W] == '0);
                  end
               end
            end
            RUN: begin
               if (!stop) begin
                  presc_q <= prec_tick ? '0 : presc_q + PW'(1);
                  for (int unsigned i = 0; i < CHANNELS; i++) begin
                     if (!done_q[i] && prec_tick) begin
                        if (sub_q[i] == ratio_q[i] - RATIO_W'(1)) begin
                           sub_q[i]   <= '0;
                           tick_q[i]  <= 1'b1;
                           count_q[i] <= count_q[i] + CNT_W'(1);
                           if (count_q[i] + CNT_W'(1) == limit_q[i])
                              done_q[i] <= 1'b1;
                        end else begin
                           sub_q[i] <= sub_q[i] + RATIO_W'(1);
                        end
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      unit_count = '0;
      for (int unsigned i = 0; i < CHANNELS; i++)
         unit_count[i*CNT_W +: CNT_W] = count_q[i];
   end

   assign tick     = tick_q;
   assign done     = done_q;
   assign busy     = busy_q;
   assign all_done = all_done_q;

endmodule

// File: tb/tb_ts_tick_gen.sv
// Directed bench for ts_tick_gen with CHANNELS=2, PREC_DIV=4.
module tb_ts_tick_gen;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic        stop;
   logic [15:0] unit_ratio;
   logic [31:0] unit_limit;
   logic [1:0]  tick;
   logic [31:0] unit_count;
   logic [1:0]  done;
   logic        busy;
   logic        all_done;

   int n_tests = 0;
   int n_fail  = 0;

   ts_tick_gen #(
      .CHANNELS(2),
      .PREC_DIV(4),
      .RATIO_W (8),
      .CNT_W   (16)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .stop      (stop),
      .unit_ratio(unit_ratio),
      .unit_limit(unit_limit),
      .tick      (tick),
      .unit_count(unit_count),
      .done      (done),
      .busy      (busy),
      .all_done  (all_done)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Hand-derived timeline for ratio {3,1}, limit {2,5}, start at cycle 0:
   // {busy, all_done, done[1:0], tick[1:0]}
   function automatic logic [5:0] exp_flags(input int c);
      logic t0, t1, d0, d1, ad, b;
      t0 = (c == 5) || (c == 9) || (c == 13) || (c == 17) || (c == 21);
      t1 = (c == 13) || (c == 25);
      d0 = (c >= 21);
      d1 = (c >= 25);
      ad = (c == 26);
      b  = (c >= 1) && (c <= 26);
      return {b, ad, d1, d0, t1, t0};
   endfunction

   function automatic logic [31:0] exp_count(input int c);
      int c0, c1;
      c0 = int'(c >= 5) + int'(c >= 9) + int'(c >= 13) + int'(c >= 17) + int'(c >= 21);
      c1 = int'(c >= 13) + int'(c >= 25);
      return {16'(c1), 16'(c0)};
   endfunction

   task automatic load_basic();
      unit_ratio = {8'd3, 8'd1};
      unit_limit = {16'd2, 16'd5};
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      start   = 1'b1;
      stop    = 1'b0;
      load_basic();
      repeat (3) step();
      n_tests++;
      if ({busy, all_done, done, tick} !== 6'b0 || unit_count !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got flags=%b count=%h, want 0", {busy, all_done, done, tick}, unit_count);
      end
      reset_n = 1'b1;
      start   = 1'b0;
      step();
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_basic();
      load_basic();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         n_tests++;
         if ({busy, all_done, done, tick} !== exp_flags(c)) begin
            n_fail++;
            $display("FAIL basic_flags c=%0d: got %b want %b", c, {busy, all_done, done, tick}, exp_flags(c));
         end
         n_tests++;
         if (unit_count !== exp_count(c)) begin
            n_fail++;
            $display("FAIL basic_count c=%0d: got %h want %h", c, unit_count, exp_count(c));
         end
         step();
      end
   endtask

   task automatic test_zero_limit();
      unit_ratio = {8'd5, 8'd5};
      unit_limit = 32'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         n_tests++;
         if ({busy, all_done, done, tick} !== {1'(c <= 2), 1'(c == 2), 2'b11, 2'b00}) begin
            n_fail++;
            $display("FAIL zero_limit c=%0d: got %b want %b", c, {busy, all_done, done, tick},
                     {1'(c <= 2), 1'(c == 2), 2'b11, 2'b00});
         end
         step();
      end
      // stop in the same cycle the run would complete: no all_done
      start = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b1;
      step();
      stop  = 1'b0;
      n_tests++;
      if ({busy, all_done} !== 2'b00) begin
         n_fail++;
         $display("FAIL stop_priority: got busy/all_done=%b want 00", {busy, all_done});
      end
      step();
      n_tests++;
      if (all_done !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_priority_late: got all_done=%b want 0", all_done);
      end
   endtask

   task automatic test_ratio_zero();
      unit_ratio = 16'd0;
      unit_limit = {16'd1, 16'd1};
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         n_tests++;
         if ({busy, all_done, done, tick} !==
             {1'(c <= 6), 1'(c == 6), (c >= 5) ? 2'b11 : 2'b00, (c == 5) ? 2'b11 : 2'b00}) begin
            n_fail++;
            $display("FAIL ratio_zero c=%0d: got %b", c, {busy, all_done, done, tick});
         end
         step();
      end
      n_tests++;
      if (unit_count !== {16'd1, 16'd1}) begin
         n_fail++;
         $display("FAIL ratio_zero_count: got %h want 00010001", unit_count);
      end
   endtask

   task automatic test_stop();
      load_basic();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         start = (c == 3);
         stop  = (c == 10);
         n_tests++;
         if ({busy, all_done, done, tick} !== exp_flags(c) || unit_count !== exp_count(c)) begin
            n_fail++;
            $display("FAIL stop_pre c=%0d: got %b/%h want %b/%h", c, {busy, all_done, done, tick},
                     unit_count, exp_flags(c), exp_count(c));
         end
         step();
      end
      start = 1'b0;
      stop  = 1'b0;
      for (int c = 11; c <= 30; c++) begin
         n_tests++;
         if ({busy, all_done, done, tick} !== 6'b0 || unit_count !== {16'd0, 16'd2}) begin
            n_fail++;
            $display("FAIL stop_post c=%0d: got %b/%h want 000000/00000002", c,
                     {busy, all_done, done, tick}, unit_count);
         end
         step();
      end
   endtask

   task automatic test_reset_midrun();
      load_basic();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         reset_n = (c != 15);
         n_tests++;
         if ({busy, all_done, done, tick} !== exp_flags(c)) begin
            n_fail++;
            $display("FAIL midrun_pre c=%0d: got %b want %b", c, {busy, all_done, done, tick}, exp_flags(c));
         end
         step();
      end
      reset_n = 1'b1;
      n_tests++;
      if ({busy, all_done, done, tick} !== 6'b0 || unit_count !== 32'd0) begin
         n_fail++;
         $display("FAIL midrun_reset: got %b/%h want 0", {busy, all_done, done, tick}, unit_count);
      end
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 18; c <= 45; c++) begin
         n_tests++;
         if ({busy, all_done, done, tick} !== exp_flags(c - 17) || unit_count !== exp_count(c - 17)) begin
            n_fail++;
            $display("FAIL restart c=%0d: got %b/%h want %b/%h", c, {busy, all_done, done, tick},
                     unit_count, exp_flags(c - 17), exp_count(c - 17));
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_limit();
      test_ratio_zero();
      test_stop();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
